// File: rtl/dp_ram_loader.sv
// dp_ram_loader: stream-to-memory writer for a dual-port RAM.
// A start command latches a base address and a word count. The block then
// accepts that many words on a valid/ready stream and writes them to
// consecutive addresses. The write address wraps at the top of memory.
// A separate registered read port works like a ROM and ignores the FSM.
// Optional feature macro: DP_RAM_LOADER_CHECKSUM_EN adds a running XOR
// checksum of accepted words on port 'checksum'.

module dp_ram_loader #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
`ifdef DP_RAM_LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
  logic                  mem_we;
  logic                  hs;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

`ifdef DP_RAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
`endif

  // The outputs decode only the registered state. s_ready never depends on s_valid.
  assign s_ready  = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign wr_count = wr_count_q;
  assign rd_data  = rd_data_q;
  assign hs       = s_valid && (state_q == LOAD);

`ifdef DP_RAM_LOADER_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

  // Next-state logic: command acceptance, write sequencing and completion detection.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    len_d      = len_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
`ifdef DP_RAM_LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Any accepted start begins a fresh load, including a zero-length one.
          wr_addr_d  = base_addr;
          len_d      = length;
          wr_count_d = '0;
`ifdef DP_RAM_LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
          state_d    = (length != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (hs) begin
          mem_we     = 1'b1;
          wr_addr_d  = wr_addr_q + ADDR_ONE;  // wraps modulo the memory depth
          wr_count_d = wr_count_q + CNT_ONE;
`ifdef DP_RAM_LOADER_CHECKSUM_EN
          checksum_d = checksum_q ^ s_data;
`endif
          if ((wr_count_q + CNT_ONE) == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers. Reset returns the FSM to IDLE and does not pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Latched command and address pointer. These are only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    wr_addr_q <= wr_addr_d;
    len_q     <= len_d;
  end

`ifdef DP_RAM_LOADER_CHECKSUM_EN
  // Running XOR of the accepted words. It holds its value after done until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end
`endif

  // RAM write port. The contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr_q] <= s_data;
    end
  end

  // Registered read port. A same-cycle write to the same address returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

endmodule
